// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq.
// The Overflow signal exists only when ALU_SEQ_OVERFLOW_EN is defined.
interface alu_seq_if #(
  parameter int WIDTH     = 32,
  parameter int CTRL_BITS = 5
);
  logic                 InValid;
  logic                 InReady;
  logic [CTRL_BITS-1:0] ALUControl;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 OutValid;
  logic                 OutReady;
  logic [WIDTH-1:0]     ALUResult;
  logic [WIDTH-1:0]     Hi;
  logic                 Zero;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic                 Overflow;

  modport master (
    output InValid, ALUControl, A, B, OutReady,
    input  InReady, OutValid, ALUResult, Hi, Zero, Overflow
  );

  modport slave (
    input  InValid, ALUControl, A, B, OutReady,
    output InReady, OutValid, ALUResult, Hi, Zero, Overflow
  );
`else
  modport master (
    output InValid, ALUControl, A, B, OutReady,
    input  InReady, OutValid, ALUResult, Hi, Zero
  );

  modport slave (
    input  InValid, ALUControl, A, B, OutReady,
    output InReady, OutValid, ALUResult, Hi, Zero
  );
`endif
endinterface

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift ops plus radix-2 multi-cycle
// MULT/MULTU/DIV/DIVU with a Hi/Lo result pair. Optional Overflow output: ALU_SEQ_OVERFLOW_EN.
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int CTRL_BITS  = 5,
  parameter int SHAMT_BITS = $clog2(WIDTH)
) (
  input logic      Clk,
  input logic      Reset,
  alu_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [CTRL_BITS-1:0] OP_AND   = CTRL_BITS'(0);
  localparam logic [CTRL_BITS-1:0] OP_OR    = CTRL_BITS'(1);
  localparam logic [CTRL_BITS-1:0] OP_ADD   = CTRL_BITS'(2);
  localparam logic [CTRL_BITS-1:0] OP_NOR   = CTRL_BITS'(3);
  localparam logic [CTRL_BITS-1:0] OP_XOR   = CTRL_BITS'(4);
  localparam logic [CTRL_BITS-1:0] OP_SUB   = CTRL_BITS'(6);
  localparam logic [CTRL_BITS-1:0] OP_SLT   = CTRL_BITS'(7);
  localparam logic [CTRL_BITS-1:0] OP_MUL   = CTRL_BITS'(9);
  localparam logic [CTRL_BITS-1:0] OP_SLL   = CTRL_BITS'(10);
  localparam logic [CTRL_BITS-1:0] OP_SGT   = CTRL_BITS'(11);
  localparam logic [CTRL_BITS-1:0] OP_SRL   = CTRL_BITS'(12);
  localparam logic [CTRL_BITS-1:0] OP_ROTR  = CTRL_BITS'(13);
  localparam logic [CTRL_BITS-1:0] OP_SLTU  = CTRL_BITS'(14);
  localparam logic [CTRL_BITS-1:0] OP_SRA   = CTRL_BITS'(15);
  localparam logic [CTRL_BITS-1:0] OP_MULT  = CTRL_BITS'(16);
  localparam logic [CTRL_BITS-1:0] OP_MULTU = CTRL_BITS'(17);
  localparam logic [CTRL_BITS-1:0] OP_DIV   = CTRL_BITS'(18);
  localparam logic [CTRL_BITS-1:0] OP_DIVU  = CTRL_BITS'(19);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    magnitude = (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             is_smul_q, is_smul_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hout_q, hout_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SHAMT_BITS-1:0] shamt_s;
  logic [SHAMT_BITS:0]   rot_l_s;
  logic [WIDTH-1:0]      sum_s, diff_s, mul_lo_s, sc_res_s;
  logic                  is_multi_s, is_div_op_s, is_signed_op_s;
  logic                  load_sc_s, load_fin_s;
  logic [WIDTH:0]        mul_sum_s, div_sh_s;
  logic                  div_ge_s;
  logic [WIDTH-1:0]      step_hi_s, step_lo_s, fin_hi_s, fin_lo_s;
  logic [2*WIDTH-1:0]    prod_s;

  assign shamt_s  = bus.B[SHAMT_BITS-1:0];
  assign rot_l_s  = (SHAMT_BITS+1)'(WIDTH) - {1'b0, shamt_s};
  assign sum_s    = bus.A + bus.B;
  assign diff_s   = bus.A - bus.B;
  assign mul_lo_s = bus.A * bus.B;

  assign is_div_op_s    = (bus.ALUControl == OP_DIV) || (bus.ALUControl == OP_DIVU);
  assign is_signed_op_s = (bus.ALUControl == OP_MULT) || (bus.ALUControl == OP_DIV);
  assign is_multi_s     = is_div_op_s || (bus.ALUControl == OP_MULT) || (bus.ALUControl == OP_MULTU);

  // Edges on which the result registers load (DONE entry).
  assign load_sc_s  = (state_q == ST_IDLE) && bus.InValid && !is_multi_s;
  assign load_fin_s = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);

  // Single-cycle result, computed from the live operands at the acceptance edge.
  always_comb begin
    sc_res_s = '0;
    case (bus.ALUControl)
      OP_AND:  sc_res_s = bus.A & bus.B;
      OP_OR:   sc_res_s = bus.A | bus.B;
      OP_ADD:  sc_res_s = sum_s;
      OP_NOR:  sc_res_s = ~(bus.A | bus.B);
      OP_XOR:  sc_res_s = bus.A ^ bus.B;
      OP_SUB:  sc_res_s = diff_s;
      OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SGT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.A) > $signed(bus.B))};
      OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_MUL:  sc_res_s = mul_lo_s;
      OP_SLL:  sc_res_s = bus.A << shamt_s;
      OP_SRL:  sc_res_s = bus.A >> shamt_s;
      OP_ROTR: sc_res_s = (bus.A >> shamt_s) | (bus.A << rot_l_s);
      OP_SRA:  sc_res_s = $unsigned($signed(bus.A) >>> shamt_s);
      default: sc_res_s = '0;
    endcase
  end

  // One radix-2 step on magnitudes: shift-add multiply or restoring divide.
  // With a zero divisor every step "subtracts" 0, leaving quotient all ones and remainder |A|.
  assign mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
  assign div_sh_s  = {hi_q, lo_q[WIDTH-1]};
  assign div_ge_s  = (div_sh_s >= {1'b0, m_q});

  // Step select and sign correction of the last step into the final Hi/Lo pair.
  always_comb begin
    prod_s = '0;
    if (is_div_q) begin
      step_hi_s = div_ge_s ? (div_sh_s[WIDTH-1:0] - m_q) : div_sh_s[WIDTH-1:0];
      step_lo_s = {lo_q[WIDTH-2:0], div_ge_s};
      fin_lo_s  = qneg_q ? (~step_lo_s + WIDTH'(1)) : step_lo_s;
      fin_hi_s  = rneg_q ? (~step_hi_s + WIDTH'(1)) : step_hi_s;
    end else begin
      step_hi_s = mul_sum_s[WIDTH:1];
      step_lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
      prod_s    = qneg_q ? (~{step_hi_s, step_lo_s} + (2*WIDTH)'(1)) : {step_hi_s, step_lo_s};
      fin_hi_s  = prod_s[2*WIDTH-1:WIDTH];
      fin_lo_s  = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM and datapath next-state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    is_smul_d = is_smul_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    m_d       = m_q;
    res_d     = res_q;
    hout_d    = hout_q;
    zero_d    = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.InValid && is_multi_s) begin
          state_d   = ST_BUSY;
          cnt_d     = '0;
          is_div_d  = is_div_op_s;
          is_smul_d = (bus.ALUControl == OP_MULT);
          qneg_d    = is_signed_op_s && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) && (bus.B != '0);
          rneg_d    = is_signed_op_s && bus.A[WIDTH-1];
          hi_d      = '0;
          lo_d      = magnitude(bus.A, is_signed_op_s);
          m_d       = magnitude(bus.B, is_signed_op_s);
        end else if (bus.InValid) begin
          state_d = ST_DONE;
          res_d   = sc_res_s;
          hout_d  = '0;
          zero_d  = (sc_res_s == '0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        hi_d = step_hi_s;
        lo_d = step_lo_s;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          res_d   = fin_lo_s;
          hout_d  = fin_hi_s;
          zero_d  = (fin_lo_s == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.OutReady) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State registers with synchronous reset; reset also drops any op in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_smul_q   <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      m_q         <= '0;
      res_q       <= '0;
      hout_q      <= '0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      is_smul_q   <= is_smul_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      m_q         <= m_d;
      res_q       <= res_d;
      hout_q      <= hout_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.InReady   = in_ready_q;
  assign bus.OutValid  = out_valid_q;
  assign bus.ALUResult = res_q;
  assign bus.Hi        = hout_q;
  assign bus.Zero      = zero_q;

`ifdef ALU_SEQ_OVERFLOW_EN
  logic sc_ovf_s, fin_ovf_s, ovf_q, ovf_d;

  // Signed overflow for ADD/SUB: result sign disagrees with A where it must not.
  always_comb begin
    case (bus.ALUControl)
      OP_ADD:  sc_ovf_s = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
      OP_SUB:  sc_ovf_s = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_s[WIDTH-1] != bus.A[WIDTH-1]);
      default: sc_ovf_s = 1'b0;
    endcase
  end

  assign fin_ovf_s = is_smul_q && (fin_hi_s != {WIDTH{fin_lo_s[WIDTH-1]}});

  // Overflow loads alongside ALUResult.
  always_comb begin
    if (load_sc_s) begin
      ovf_d = sc_ovf_s;
    end else if (load_fin_s) begin
      ovf_d = fin_ovf_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;

  logic Clk;
  logic Reset;
  int   tests;
  int   fails;

  alu_seq_if #(.WIDTH(32), .CTRL_BITS(5)) bus ();

  alu_seq #(.WIDTH(32), .CTRL_BITS(5), .SHAMT_BITS(5)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one op from a post-edge slot, scramble inputs after acceptance,
  // and count edges until OutValid (1 = visible right after the accept edge).
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    bus.InValid    = 1'b1;
    bus.ALUControl = op;
    bus.A          = a;
    bus.B          = b;
    @(posedge Clk); #1;
    bus.InValid    = 1'b0;
    bus.ALUControl = 5'd2;
    bus.A          = 32'hDEADBEEF;
    bus.B          = 32'h0BADF00D;
    lat = 1;
    while (bus.OutValid !== 1'b1 && lat < 80) begin
      @(posedge Clk); #1;
      lat = lat + 1;
    end
  endtask

  task automatic consume();
    bus.OutReady = 1'b1;
    @(posedge Clk); #1;
    bus.OutReady = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    tests = tests + 1;
    if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL reset_hs: InReady=%b OutValid=%b expected 1/0", bus.InReady, bus.OutValid);
    end
    tests = tests + 1;
    if (bus.ALUResult !== 32'h0 || bus.Hi !== 32'h0 || bus.Zero !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL reset_out: res=%h hi=%h zero=%b expected 0/0/1", bus.ALUResult, bus.Hi, bus.Zero);
    end
`ifdef ALU_SEQ_OVERFLOW_EN
    tests = tests + 1;
    if (bus.Overflow !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL reset_ovf: got %b expected 0", bus.Overflow);
    end
`endif
    @(posedge Clk); #1;
    tests = tests + 1;
    if (bus.InReady !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL reset_idle: InReady=%b expected 1", bus.InReady);
    end
  endtask

  task automatic test_add_overflow();
    int lat;
    issue(5'd2, 32'h7FFFFFFF, 32'h00000001, lat);
    tests = tests + 1;
    if (lat !== 1) begin
      fails = fails + 1;
      $display("FAIL add_latency: got %0d expected 1", lat);
    end
    tests = tests + 1;
    if (bus.ALUResult !== 32'h80000000 || bus.Hi !== 32'h0 || bus.Zero !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL add_result: res=%h hi=%h zero=%b expected 80000000/0/0", bus.ALUResult, bus.Hi, bus.Zero);
    end
`ifdef ALU_SEQ_OVERFLOW_EN
    tests = tests + 1;
    if (bus.Overflow !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL add_ovf: got %b expected 1", bus.Overflow);
    end
`endif
    consume();
  endtask

  task automatic test_sub_hold();
    int lat;
    issue(5'd6, 32'd5, 32'd5, lat);
    tests = tests + 1;
    if (lat !== 1) begin
      fails = fails + 1;
      $display("FAIL sub_latency: got %0d expected 1", lat);
    end
    // A competing request while DONE must not be taken.
    bus.InValid    = 1'b1;
    bus.ALUControl = 5'd2;
    bus.A          = 32'd1;
    bus.B          = 32'd1;
    for (int i = 0; i < 3; i++) begin
      tests = tests + 1;
      if (bus.OutValid !== 1'b1 || bus.InReady !== 1'b0 || bus.ALUResult !== 32'h0 || bus.Zero !== 1'b1) begin
        fails = fails + 1;
        $display("FAIL sub_hold[%0d]: ov=%b ir=%b res=%h zero=%b expected 1/0/0/1",
                 i, bus.OutValid, bus.InReady, bus.ALUResult, bus.Zero);
      end
      @(posedge Clk); #1;
    end
    bus.OutReady = 1'b1;
    @(posedge Clk); #1;
    bus.OutReady = 1'b0;
    tests = tests + 1;
    if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0 || bus.ALUResult !== 32'h0) begin
      fails = fails + 1;
      $display("FAIL sub_release: ir=%b ov=%b res=%h expected 1/0/0", bus.InReady, bus.OutValid, bus.ALUResult);
    end
    bus.InValid = 1'b0;
  endtask

  task automatic test_single_ops();
    logic [4:0]  ops [18];
    logic [31:0] as  [18];
    logic [31:0] bs  [18];
    logic [31:0] exs [18];
    int lat;
    ops = '{5'd15, 5'd13, 5'd7, 5'd14, 5'd0, 5'd1, 5'd3, 5'd4, 5'd11,
            5'd9, 5'd10, 5'd12, 5'd13, 5'd5, 5'd20, 5'd31, 5'd13, 5'd6};
    as  = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0,
            32'hF0F0F0F0, 32'hFFFF0000, 32'h00000001, 32'h00012345, 32'h00000003, 32'h80000000,
            32'h12345678, 32'h00001234, 32'h00001234, 32'hFFFFFFFF, 32'h12345678, 32'h00000003};
    bs  = '{32'd31, 32'd1, 32'd1, 32'd1, 32'hFF00FF00, 32'h0F0F0000,
            32'h0F0F0000, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'h00001000, 32'h00000104, 32'h0000001F,
            32'h00000020, 32'h00005678, 32'h00005678, 32'hFFFFFFFF, 32'h00000008, 32'h00000005};
    exs = '{32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h00000000, 32'hF000F000, 32'hFFFFF0F0,
            32'h00000F0F, 32'hF0F00F0F, 32'h00000001, 32'h12345000, 32'h00000030, 32'h00000001,
            32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 32'h78123456, 32'hFFFFFFFE};
    for (int i = 0; i < 18; i++) begin
      issue(ops[i], as[i], bs[i], lat);
      tests = tests + 1;
      if (lat !== 1 || bus.ALUResult !== exs[i] || bus.Hi !== 32'h0 || bus.Zero !== (exs[i] == 32'h0)) begin
        fails = fails + 1;
        $display("FAIL single_op[%0d] code %0d: lat=%0d res=%h hi=%h zero=%b expected lat 1 res %h hi 0",
                 i, ops[i], lat, bus.ALUResult, bus.Hi, bus.Zero, exs[i]);
      end
`ifdef ALU_SEQ_OVERFLOW_EN
      tests = tests + 1;
      if (bus.Overflow !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL single_ovf[%0d]: got %b expected 0", i, bus.Overflow);
      end
`endif
      consume();
    end
  endtask

  task automatic test_mult();
    logic [4:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    logic [31:0] ehi [4];
    logic [31:0] elo [4];
    logic        eov [4];
    int lat;
    ops = '{5'd16, 5'd17, 5'd16, 5'd16};
    as  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00010000, 32'h80000000};
    bs  = '{32'h00000003, 32'h00000003, 32'h00010000, 32'h80000000};
    ehi = '{32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h40000000};
    elo = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'h00000000, 32'h00000000};
    eov = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], lat);
      tests = tests + 1;
      if (lat !== 33) begin
        fails = fails + 1;
        $display("FAIL mult_latency[%0d]: got %0d expected 33", i, lat);
      end
      tests = tests + 1;
      if (bus.Hi !== ehi[i] || bus.ALUResult !== elo[i] || bus.Zero !== (elo[i] == 32'h0)) begin
        fails = fails + 1;
        $display("FAIL mult_result[%0d]: hi=%h lo=%h zero=%b expected %h/%h", i, bus.Hi, bus.ALUResult, bus.Zero, ehi[i], elo[i]);
      end
`ifdef ALU_SEQ_OVERFLOW_EN
      tests = tests + 1;
      if (bus.Overflow !== eov[i]) begin
        fails = fails + 1;
        $display("FAIL mult_ovf[%0d]: got %b expected %b", i, bus.Overflow, eov[i]);
      end
`else
      if (eov[i] === 1'bx) $display("unexpected table entry");
`endif
      consume();
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [6];
    logic [31:0] as  [6];
    logic [31:0] bs  [6];
    logic [31:0] ehi [6];
    logic [31:0] elo [6];
    int lat;
    ops = '{5'd18, 5'd19, 5'd18, 5'd18, 5'd19, 5'd18};
    as  = '{32'hFFFFFFF9, 32'h00000007, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'h00000007};
    bs  = '{32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000010, 32'hFFFFFFFE};
    elo = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'hFFFFFFFD};
    ehi = '{32'hFFFFFFFF, 32'h00000007, 32'h00000000, 32'hFFFFFFFB, 32'h0000000F, 32'h00000001};
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], lat);
      tests = tests + 1;
      if (lat !== 33) begin
        fails = fails + 1;
        $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat);
      end
      tests = tests + 1;
      if (bus.ALUResult !== elo[i] || bus.Hi !== ehi[i] || bus.Zero !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL div_result[%0d]: q=%h r=%h zero=%b expected %h/%h/0", i, bus.ALUResult, bus.Hi, bus.Zero, elo[i], ehi[i]);
      end
      consume();
    end
  endtask

  task automatic test_reset_mid_div();
    int lat;
    int bad;
    bus.InValid    = 1'b1;
    bus.ALUControl = 5'd18;
    bus.A          = 32'd100;
    bus.B          = 32'd7;
    @(posedge Clk); #1;
    bus.InValid = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    tests = tests + 1;
    if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0 || bus.ALUResult !== 32'h0 || bus.Hi !== 32'h0 || bus.Zero !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL abort_state: ir=%b ov=%b res=%h hi=%h zero=%b expected 1/0/0/0/1",
               bus.InReady, bus.OutValid, bus.ALUResult, bus.Hi, bus.Zero);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (bus.OutValid !== 1'b0) bad = 1;
    end
    tests = tests + 1;
    if (bad != 0) begin
      fails = fails + 1;
      $display("FAIL abort_discard: OutValid rose after abort, expected 0");
    end
    issue(5'd2, 32'd2, 32'd3, lat);
    tests = tests + 1;
    if (lat !== 1 || bus.ALUResult !== 32'd5 || bus.Zero !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL abort_then_add: lat=%0d res=%h expected 1/00000005", lat, bus.ALUResult);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    bus.OutReady   = 1'b1;
    bus.InValid    = 1'b1;
    bus.ALUControl = 5'd2;
    bus.A          = 32'd1;
    bus.B          = 32'd1;
    @(posedge Clk); #1;
    tests = tests + 1;
    if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'd2) begin
      fails = fails + 1;
      $display("FAIL b2b_first: ov=%b res=%h expected 1/00000002", bus.OutValid, bus.ALUResult);
    end
    bus.A = 32'd10;
    bus.B = 32'd20;
    @(posedge Clk); #1;
    tests = tests + 1;
    if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1 || bus.ALUResult !== 32'd2) begin
      fails = fails + 1;
      $display("FAIL b2b_gap: ov=%b ir=%b res=%h expected 0/1/00000002", bus.OutValid, bus.InReady, bus.ALUResult);
    end
    @(posedge Clk); #1;
    bus.InValid = 1'b0;
    tests = tests + 1;
    if (bus.OutValid !== 1'b1 || bus.ALUResult !== 32'd30) begin
      fails = fails + 1;
      $display("FAIL b2b_second: ov=%b res=%h expected 1/0000001e", bus.OutValid, bus.ALUResult);
    end
    @(posedge Clk); #1;
    bus.OutReady = 1'b0;
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    Reset          = 1'b1;
    bus.InValid    = 1'b0;
    bus.OutReady   = 1'b0;
    bus.ALUControl = 5'd0;
    bus.A          = 32'h0;
    bus.B          = 32'h0;
    test_reset();
    test_add_overflow();
    test_sub_hold();
    test_single_ops();
    test_mult();
    test_div();
    test_reset_mid_div();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
